// File: rtl/ball_track_ctrl_pkg.sv
// Shared definitions for the ball centroid tracker: coordinate width, FSM encoding, defaults.
// smooth_step is only used when the top is built with BALL_SMOOTH_EN.
package ball_track_ctrl_pkg;

  localparam int COORD_W        = 13;
  localparam int MIN_PIXELS_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_DIV_R  = 3'd2,
    ST_DIV_C  = 3'd3,
    ST_UPDATE = 3'd4
  } state_e;

  // Quarter-step low-pass toward the new measurement; signed difference, arithmetic shift.
  function automatic logic [COORD_W-1:0] smooth_step(input logic [COORD_W-1:0] old_v,
                                                     input logic [COORD_W-1:0] meas_v);
    logic signed [COORD_W:0] diff;
    diff = $signed({1'b0, meas_v}) - $signed({1'b0, old_v});
    return old_v + COORD_W'(diff >>> 2);
  endfunction

endpackage

// File: rtl/ball_track_ctrl_seq_udiv.sv
// Unsigned restoring shift-subtract divider, one quotient bit per cycle, DW cycles per division.
// The start cycle already performs the first step using the dividend/divisor inputs directly.
module seq_udiv #(
  parameter int DW = 28,
  parameter int VW = 19,
  parameter int QW = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          busy_o,
  output logic          last_o,
  output logic [QW-1:0] quot_o
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0] quo_q, quo_d, src_quo;
  logic [VW-1:0] rem_q, rem_d, src_rem;
  logic [VW-1:0] dvs_q, src_dvs;
  logic [VW:0]   shifted;
  logic          ge;
  logic          busy_q;
  logic [CW-1:0] cnt_q;

  always_comb begin
    src_quo = start_i ? dividend_i : quo_q;
    src_rem = start_i ? '0 : rem_q;
    src_dvs = start_i ? divisor_i : dvs_q;
    shifted = {src_rem, src_quo[DW-1]};
    ge      = (shifted >= {1'b0, src_dvs});
    rem_d   = ge ? VW'(shifted - {1'b0, src_dvs}) : VW'(shifted);
    quo_d   = {src_quo[DW-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i || busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      if (start_i) begin
        dvs_q  <= divisor_i;
        cnt_q  <= CW'(1);
        busy_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        if (last_o) busy_q <= 1'b0;
      end
    end
  end

  assign busy_o = busy_q;
  assign last_o = busy_q && (cnt_q == CW'(DW - 1));
  assign quot_o = quo_q[QW-1:0];

endmodule

// File: rtl/ball_track_ctrl.sv
// Ball centroid tracker: accumulates masked pixel coordinates per frame, divides by the count
// and publishes the position. Optional BALL_SMOOTH_EN low-pass filters successive positions.
module ball_track_ctrl
  import ball_track_ctrl_pkg::*;
#(
  parameter int MIN_PIXELS = MIN_PIXELS_DEF,
  parameter int SUM_W      = 28,
  parameter int CNT_W      = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic               mask,
  input  logic               frame_end,
  output logic [COORD_W-1:0] ball_row,
  output logic [COORD_W-1:0] ball_col,
  output logic               ball_valid,
  output logic               upd,
  output logic               busy,
  output logic               drop,
  output state_e             dbg_state_o
);

  state_e state_q, state_d;

  logic [SUM_W-1:0]   sum_r_q, sum_r_d, sum_c_q, sum_c_d, snap_r_q, snap_c_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, snap_n_q;
  logic [SUM_W:0]     sr_ext, sc_ext;
  logic [CNT_W:0]     n_ext;
  logic               hit, qualify, drop_q, upd_q, ball_valid_q;
  logic               div_start, div_busy, div_last;
  logic [SUM_W-1:0]   div_dividend;
  logic [COORD_W-1:0] div_quot, row_meas_q, ball_row_q, ball_col_q, new_r, new_c;

  // Saturating accumulation; a pixel coincident with frame_end lands in the snapshot.
  always_comb begin
    hit     = pix_valid & mask;
    sr_ext  = {1'b0, sum_r_q} + (SUM_W+1)'(row);
    sc_ext  = {1'b0, sum_c_q} + (SUM_W+1)'(col);
    n_ext   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    sum_r_d = sum_r_q;
    sum_c_d = sum_c_q;
    cnt_d   = cnt_q;
    if (hit) begin
      sum_r_d = sr_ext[SUM_W] ? '1 : sr_ext[SUM_W-1:0];
      sum_c_d = sc_ext[SUM_W] ? '1 : sc_ext[SUM_W-1:0];
      cnt_d   = n_ext[CNT_W]  ? '1 : n_ext[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r_q  <= '0;
      sum_c_q  <= '0;
      cnt_q    <= '0;
      snap_r_q <= '0;
      snap_c_q <= '0;
      snap_n_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= frame_end && (state_q != ST_IDLE);
      if (frame_end) begin
        sum_r_q <= '0;
        sum_c_q <= '0;
        cnt_q   <= '0;
        if (state_q == ST_IDLE) begin
          snap_r_q <= sum_r_d;
          snap_c_q <= sum_c_d;
          snap_n_q <= cnt_d;
        end
      end else begin
        sum_r_q <= sum_r_d;
        sum_c_q <= sum_c_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  assign qualify = (snap_n_q >= CNT_W'(MIN_PIXELS));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (frame_end) state_d = ST_CHECK;
      ST_CHECK:  state_d = qualify ? ST_DIV_R : ST_IDLE;
      ST_DIV_R:  if (div_last) state_d = ST_DIV_C;
      ST_DIV_C:  if (div_last) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Row division starts in CHECK, column division on the first DIV_C cycle.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    div_start    = 1'b0;
    div_dividend = snap_r_q;
    dbg_state_o  = state_q;
    case (state_q)
      ST_CHECK: div_start = qualify;
      ST_DIV_C: begin
        div_start    = !div_busy;
        div_dividend = snap_c_q;
      end
      default: ;
    endcase
  end

  seq_udiv #(.DW(SUM_W), .VW(CNT_W), .QW(COORD_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start_i   (div_start),
    .dividend_i(div_dividend),
    .divisor_i (snap_n_q),
    .busy_o    (div_busy),
    .last_o    (div_last),
    .quot_o    (div_quot)
  );

  always_comb begin
`ifdef BALL_SMOOTH_EN
    new_r = ball_valid_q ? smooth_step(ball_row_q, row_meas_q) : row_meas_q;
    new_c = ball_valid_q ? smooth_step(ball_col_q, div_quot) : div_quot;
`else
    new_r = row_meas_q;
    new_c = div_quot;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meas_q   <= '0;
      ball_row_q   <= '0;
      ball_col_q   <= '0;
      ball_valid_q <= 1'b0;
      upd_q        <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (state_q == ST_DIV_C && div_start) row_meas_q <= div_quot;
      if (state_q == ST_CHECK && !qualify) begin
        ball_valid_q <= 1'b0;
        upd_q        <= 1'b1;
      end
      if (state_q == ST_UPDATE) begin
        ball_row_q   <= new_r;
        ball_col_q   <= new_c;
        ball_valid_q <= 1'b1;
        upd_q        <= 1'b1;
      end
    end
  end

  assign ball_row   = ball_row_q;
  assign ball_col   = ball_col_q;
  assign ball_valid = ball_valid_q;
  assign upd        = upd_q;
  assign drop       = drop_q;

endmodule

// File: tb/tb_ball_track_ctrl.sv
// Bench for ball_track_ctrl: frame-level timeline model checked every cycle, plus directed
// frames with hand-computed positions and latencies. BALL_SMOOTH_EN adds the filter case.
module tb_ball_track_ctrl;
  import ball_track_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         reset, pix_valid, mask, frame_end;
  logic [12:0]  row, col;
  logic [12:0]  ball_row, ball_col;
  logic         ball_valid, upd, busy, drop;
  state_e       dbg_state;

  always #5 clk = ~clk;

  ball_track_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .row        (row),
    .col        (col),
    .mask       (mask),
    .frame_end  (frame_end),
    .ball_row   (ball_row),
    .ball_col   (ball_col),
    .ball_valid (ball_valid),
    .upd        (upd),
    .busy       (busy),
    .drop       (drop),
    .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: each accepted frame_end schedules a busy window and one update.
  localparam longint SMAX = (64'd1 << 28) - 1;
  localparam longint NMAX = (64'd1 << 19) - 1;
  int     edge_n = 0;
  longint m_sr = 0, m_sc = 0, m_n = 0;
  int     busy_from = -10, busy_to = -10, upd_at = -10, drop_at = -10;
  int     pend_valid = 0, pend_r = 0, pend_c = 0;
  int     exp_r = 0, exp_c = 0, exp_v = 0;
  bit     m_hit;

  always @(posedge clk) begin
    edge_n++;
    m_hit = pix_valid && mask;
    if (reset) begin
      m_sr = 0; m_sc = 0; m_n = 0;
      busy_from = -10; busy_to = -10; upd_at = -10; drop_at = -10;
      exp_r = 0; exp_c = 0; exp_v = 0;
    end else begin
      if (m_hit) begin
        m_sr = (m_sr + row > SMAX) ? SMAX : m_sr + row;
        m_sc = (m_sc + col > SMAX) ? SMAX : m_sc + col;
        m_n  = (m_n + 1 > NMAX) ? NMAX : m_n + 1;
      end
      if (frame_end) begin
        if (edge_n - 1 >= busy_from && edge_n - 1 <= busy_to) begin
          drop_at = edge_n;
        end else begin
          busy_from = edge_n;
          if (m_n >= 64) begin
            busy_to    = edge_n + 56;
            upd_at     = edge_n + 57;
            pend_valid = 1;
            pend_r     = int'((m_sr / m_n) % 8192);
            pend_c     = int'((m_sc / m_n) % 8192);
          end else begin
            busy_to    = edge_n;
            upd_at     = edge_n + 1;
            pend_valid = 0;
          end
        end
        m_sr = 0; m_sc = 0; m_n = 0;
      end
      if (edge_n == upd_at) begin
        if (pend_valid != 0) begin
`ifdef BALL_SMOOTH_EN
          if (exp_v != 0) begin
            exp_r = (exp_r + ((pend_r - exp_r) >>> 2)) & 8191;
            exp_c = (exp_c + ((pend_c - exp_c) >>> 2)) & 8191;
          end else begin
            exp_r = pend_r;
            exp_c = pend_c;
          end
`else
          exp_r = pend_r;
          exp_c = pend_c;
`endif
          exp_v = 1;
        end else begin
          exp_v = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_upd", upd, (edge_n == upd_at) ? 1 : 0);
      chk("cyc_drop", drop, (edge_n == drop_at) ? 1 : 0);
      chk("cyc_busy", busy, (edge_n >= busy_from && edge_n <= busy_to) ? 1 : 0);
      chk("cyc_valid", ball_valid, exp_v);
      chk("cyc_row", ball_row, exp_r);
      chk("cyc_col", ball_col, exp_c);
    end
  end

  task automatic drive(input bit pv, input int r, input int c, input bit m, input bit fe);
    @(negedge clk);
    pix_valid = pv;
    row       = 13'(r);
    col       = 13'(c);
    mask      = m;
    frame_end = fe;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pix_valid = 1'b0; mask = 1'b0; frame_end = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pixels(input int n, input int r, input int c);
    for (int i = 0; i < n; i++) drive(1'b1, r, c, 1'b1, 1'b0);
  endtask

  // Returns the cycle (frame_end cycle = 0) in which upd is seen.
  task automatic wait_upd(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      if (upd) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("upd_timeout", 0, 1);
  endtask

  int lat, drop_cnt, upd_cnt;

  initial begin
    reset = 1'b1; pix_valid = 1'b0; mask = 1'b0; frame_end = 1'b0; row = '0; col = '0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_row", ball_row, 0);
    chk("rst_col", ball_col, 0);
    chk("rst_valid", ball_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_upd", upd, 0);
    chk("rst_drop", drop, 0);
    reset = 1'b0;

    // 100 pixels at (200,300)
    pixels(100, 200, 300);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_upd(lat);
    chk("t1_lat", lat, 58);
    chk("t1_row", ball_row, 200);
    chk("t1_col", ball_col, 300);
    chk("t1_valid", ball_valid, 1);
    repeat (3) drive(1'b0, 0, 0, 1'b0, 1'b0);

    // 63 pixels: too few, position held
    pixels(63, 50, 60);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_upd(lat);
    chk("t2_lat", lat, 2);
    chk("t2_valid", ball_valid, 0);
    chk("t2_row", ball_row, 200);
    chk("t2_col", ball_col, 300);

    // 64th pixel coincident with frame_end
    do_reset();
    pixels(63, 10, 10);
    drive(1'b1, 10, 10, 1'b1, 1'b1);
    wait_upd(lat);
    chk("t3_lat", lat, 58);
    chk("t3_valid", ball_valid, 1);
    chk("t3_row", ball_row, 10);
    chk("t3_col", ball_col, 10);

    // Truncating quotient with ignored non-qualifying cycles: rows 0..99, cols 3*i
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, i, 3 * i, 1'b1, 1'b0);
      drive(1'b0, 4000, 4000, 1'b1, 1'b0);
      drive(1'b1, 5000, 5000, 1'b0, 1'b0);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_upd(lat);
    chk("t4_row", ball_row, 49);
    chk("t4_col", ball_col, 148);

    // Top-of-range coordinates
    do_reset();
    pixels(32, 8191, 0);
    pixels(32, 8190, 2);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_upd(lat);
    chk("t5_row", ball_row, 8190);
    chk("t5_col", ball_col, 1);

    // Second frame_end 20 cycles into the division is dropped
    do_reset();
    pixels(64, 7, 9);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drop_cnt = 0;
    lat = -1;
    for (int k = 1; k <= 120; k++) begin
      if (k < 20)       drive(1'b1, 400, 400, 1'b1, 1'b0);
      else if (k == 20) drive(1'b1, 400, 400, 1'b1, 1'b1);
      else              drive(1'b0, 0, 0, 1'b0, 1'b0);
      if (drop) drop_cnt++;
      if (upd && lat < 0) lat = k;
      if (lat > 0 && k > lat + 2) break;
    end
    chk("t6_drops", drop_cnt, 1);
    chk("t6_lat", lat, 58);
    chk("t6_row", ball_row, 7);
    chk("t6_col", ball_col, 9);
    pixels(64, 5, 6);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_upd(lat);
    chk("t6b_lat", lat, 58);
`ifdef BALL_SMOOTH_EN
    chk("t6b_row", ball_row, 6);
    chk("t6b_col", ball_col, 8);
`else
    chk("t6b_row", ball_row, 5);
    chk("t6b_col", ball_col, 6);
`endif

    // Reset 30 cycles into the division aborts it
    pixels(100, 30, 40);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    upd_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      if (upd) upd_cnt++;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("t7_row", ball_row, 0);
    chk("t7_col", ball_col, 0);
    chk("t7_valid", ball_valid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_upd", upd, 0);
    chk("t7_drop", drop, 0);
    reset = 1'b0;
    for (int k = 0; k < 80; k++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      if (upd) upd_cnt++;
    end
    chk("t7_no_upd", upd_cnt, 0);
    pixels(70, 100, 200);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_upd(lat);
    chk("t7b_lat", lat, 58);
    chk("t7b_row", ball_row, 100);
    chk("t7b_col", ball_col, 200);
    chk("t7b_valid", ball_valid, 1);

`ifdef BALL_SMOOTH_EN
    do_reset();
    pixels(64, 100, 100);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_upd(lat);
    pixels(64, 140, 60);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_upd(lat);
    chk("t8_lat", lat, 58);
    chk("t8_row", ball_row, 110);
    chk("t8_col", ball_col, 90);
`endif

    repeat (3) drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
